// File: rtl/bus16_pkg.sv
// Shared types and constants for the two-requester 16-bit register bus arbiter.
package bus16_pkg;

  localparam int BUS_DATA_W = 16;
  localparam logic [BUS_DATA_W-1:0] TIMEOUT_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_M0 = 1'b0;
  localparam req_idx_t REQ_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: registered last grant plus combinational winner select.
module rr_arb2
  import bus16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output req_idx_t   winner,
  output logic       valid
);

  req_idx_t last_grant;

  // M1 as the reset history lets M0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_M1;
    end else if (grant_en && valid) begin
      last_grant <= winner;
    end
  end

  always_comb begin
    winner = REQ_M0;
    case (req)
      2'b01:   winner = REQ_M0;
      2'b10:   winner = REQ_M1;
      2'b11:   winner = ~last_grant;
      default: winner = REQ_M0;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/bus16_arbiter_x2.sv
// Arbitrates one 16-bit CS/Wr_Rd_n register bus between requesters M0 and M1,
// one transaction in flight, with a read timeout for silent slaves.
//
//   state   | meaning
//   IDLE    | no transaction; arbitrate and latch winner's command
//   ISSUE   | CS and winner's Ack high for exactly one cycle
//   WAIT_RD | read issued; wait for Rd_DV or timeout
module bus16_arbiter_x2
  import bus16_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    RD_TIMEOUT   = 16,
  parameter logic [BUS_DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic                  i_Bus_Clk,
  input  logic                  i_Bus_Rst_L,
  input  logic                  i_M0_Req,
  input  logic                  i_M0_Wr_Rd_n,
  input  logic [ADDR_WIDTH-1:0] i_M0_Addr8,
  input  logic [BUS_DATA_W-1:0] i_M0_Wr_Data,
  output logic                  o_M0_Ack,
  output logic [BUS_DATA_W-1:0] o_M0_Rd_Data,
  output logic                  o_M0_Rd_DV,
  output logic                  o_M0_Rd_Err,
  input  logic                  i_M1_Req,
  input  logic                  i_M1_Wr_Rd_n,
  input  logic [ADDR_WIDTH-1:0] i_M1_Addr8,
  input  logic [BUS_DATA_W-1:0] i_M1_Wr_Data,
  output logic                  o_M1_Ack,
  output logic [BUS_DATA_W-1:0] o_M1_Rd_Data,
  output logic                  o_M1_Rd_DV,
  output logic                  o_M1_Rd_Err,
  output logic                  o_Bus_CS,
  output logic                  o_Bus_Wr_Rd_n,
  output logic [ADDR_WIDTH-1:0] o_Bus_Addr8,
  output logic [BUS_DATA_W-1:0] o_Bus_Wr_Data,
  input  logic [BUS_DATA_W-1:0] i_Bus_Rd_Data,
  input  logic                  i_Bus_Rd_DV
);

  localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            timer_q, timer_d;
  req_idx_t              idx_q, idx_d;
  logic                  cs_q, cs_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]            ack_q, ack_d, dv_q, dv_d, err_q, err_d;
  logic [BUS_DATA_W-1:0] rd_q [2];
  logic [BUS_DATA_W-1:0] rd_d [2];

  req_idx_t winner;
  logic     arb_valid;
  logic     grant_en;

  assign grant_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk      (i_Bus_Clk),
    .rst_n    (i_Bus_Rst_L),
    .req      ({i_M1_Req, i_M0_Req}),
    .grant_en (grant_en),
    .winner   (winner),
    .valid    (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d[0] = rd_q[0];
    rd_d[1] = rd_q[1];
    cs_d    = 1'b0;
    ack_d   = 2'b00;
    dv_d    = 2'b00;
    err_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          idx_d         = winner;
          wr_d          = winner ? i_M1_Wr_Rd_n : i_M0_Wr_Rd_n;
          addr_d        = winner ? i_M1_Addr8   : i_M0_Addr8;
          wdata_d       = winner ? i_M1_Wr_Data : i_M0_Wr_Data;
          cs_d          = 1'b1;
          ack_d[winner] = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = IDLE;
        end else begin
          timer_d = 8'd0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // DV takes priority over a timeout landing in the same cycle.
        if (i_Bus_Rd_DV) begin
          rd_d[idx_q] = i_Bus_Rd_Data;
          dv_d[idx_q] = 1'b1;
          state_d     = IDLE;
        end else if (timer_q == TMO_LAST) begin
          rd_d[idx_q]  = TIMEOUT_DATA;
          dv_d[idx_q]  = 1'b1;
          err_d[idx_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_q <= IDLE;
      timer_q <= 8'd0;
      idx_q   <= REQ_M0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 2'b00;
      dv_q    <= 2'b00;
      err_q   <= 2'b00;
      rd_q[0] <= '0;
      rd_q[1] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      rd_q[0] <= rd_d[0];
      rd_q[1] <= rd_d[1];
    end
  end

  assign o_Bus_CS      = cs_q;
  assign o_Bus_Wr_Rd_n = wr_q;
  assign o_Bus_Addr8   = addr_q;
  assign o_Bus_Wr_Data = wdata_q;
  assign o_M0_Ack      = ack_q[0];
  assign o_M1_Ack      = ack_q[1];
  assign o_M0_Rd_DV    = dv_q[0];
  assign o_M1_Rd_DV    = dv_q[1];
  assign o_M0_Rd_Err   = err_q[0];
  assign o_M1_Rd_Err   = err_q[1];
  assign o_M0_Rd_Data  = rd_q[0];
  assign o_M1_Rd_Data  = rd_q[1];

endmodule
